// File: rtl/ser_shift_ctrl_pkg.sv
// Shared FSM encoding and default word width for the serializer controller.
package ser_shift_ctrl_pkg;

  localparam int DEFAULT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/ser_shift_ctrl_piso_shift_reg.sv
// Parallel-in serial-out right-shift register with zero fill; shift wins over load.
// Single-cycle update, no backpressure of its own: the controller decides when ld/sh fire.
module piso_shift_reg
  import ser_shift_ctrl_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         sh,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (sh) begin
      r_q <= {1'b0, r_q[W-1:1]};
    end else if (ld) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/ser_shift_ctrl.sv
// Serializes W-bit words LSB-first; first bit one cycle after handshake, W+2 cycles per word.
// ser_ready low freezes the register, bit counter and state, so no bit is lost or repeated.
module ser_shift_ctrl
  import ser_shift_ctrl_pkg::*;
#(
  parameter int W  = DEFAULT_W,
  parameter int CW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          ser_out,
  output logic          ser_valid,
  input  logic          ser_ready,
  output logic [CW-1:0] bit_cnt,
  output logic          done
);

  localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_bit_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_ld;
  logic          w_sh;
  logic [W-1:0]  w_q;

  piso_shift_reg #(.W(W)) u_piso (
    .clk (clk),
    .rst (rst),
    .ld  (w_ld),
    .sh  (w_sh),
    .d   (in_data),
    .q   (w_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_bit_cnt;
    w_ld        = 1'b0;
    w_sh        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_ld        = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Only an accepted transfer advances; a stall leaves everything untouched.
        if (ser_ready) begin
          w_sh = 1'b1;
          if (r_bit_cnt == LAST_IDX) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_DONE;
          end else begin
            w_cnt_nxt = r_bit_cnt + CW'(1);
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign ser_valid = (r_state == ST_SHIFT);
  assign done      = (r_state == ST_DONE);
  assign ser_out   = w_q[0];
  assign bit_cnt   = r_bit_cnt;

endmodule

// File: tb/tb_ser_shift_ctrl.sv
// Directed and randomized checks of ser_shift_ctrl against a bit-index reference model.
module tb_ser_shift_ctrl;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic          in_ready;
  logic          ser_out;
  logic          ser_valid;
  logic          ser_ready = 1'b0;
  logic [CW-1:0] bit_cnt;
  logic          done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ser_shift_ctrl #(.W(W), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .bit_cnt   (bit_cnt),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_ser_valid"}, 32'(ser_valid), 32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_ser_out"},   32'(ser_out),   32'd0);
    chk({tag, "_bit_cnt"},   32'(bit_cnt),   32'd0);
  endtask

  // Reference model: the k-th accepted transfer must carry bit k of the word.
  // noise: 0 = quiet, 1 = in_valid/8'hFF pulse at bit 3, 2 = random in_valid/in_data.
  task automatic run_word(input logic [W-1:0] w, input int rdy_pct, input int noise,
                          input bit keep_valid, input int stall_at, input int stall_len,
                          output int t_hs);
    int idx;
    int nstall;
    int xfers;
    int forced;
    bit timed_out;
    idx = 0; nstall = 0; xfers = 0; forced = 0; timed_out = 1'b0;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = w;
    step();
    t_hs = cyc;
    in_valid = keep_valid;
    in_data  = keep_valid ? ~w : W'($urandom);
    while (idx < W) begin
      chk("ser_valid", 32'(ser_valid), 32'd1);
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      chk("done_busy", 32'(done), 32'd0);
      chk("ser_out", 32'(ser_out), 32'(w[idx]));
      chk("bit_cnt", 32'(bit_cnt), 32'(idx));
      if (idx == stall_at && forced < stall_len) begin
        ser_ready = 1'b0;
        forced++;
      end else begin
        ser_ready = ($urandom_range(99) < rdy_pct);
      end
      if (noise == 1) begin
        in_valid = (idx == 3);
        in_data  = 8'hFF;
      end else if (noise == 2) begin
        in_valid = $urandom_range(1);
        in_data  = W'($urandom);
      end
      if (ser_valid && ser_ready) xfers++;
      step();
      if (ser_ready) idx++;
      else nstall++;
      if (nstall > 300) begin
        timed_out = 1'b1;
        break;
      end
    end
    if (timed_out) begin
      chk("stall_timeout", 32'(nstall), 32'd0);
    end
    in_valid  = keep_valid;
    ser_ready = 1'b0;
    chk("latency_done", 32'(cyc - t_hs), 32'(W + nstall));
    chk("xfer_count", 32'(xfers), 32'(W));
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_ser_valid", 32'(ser_valid), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd0);
    step();
    chk("post_done", 32'(done), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
    chk("post_ser_valid", 32'(ser_valid), 32'd0);
  endtask

  initial begin
    int t_a;
    int t_b;
    logic [W-1:0] w;

    // Power-on reset, then reset held two cycles in the middle of a word.
    step();
    step();
    rst = 1'b0;
    chk_reset_state("por");
    in_valid = 1'b1;
    in_data  = 8'h5A;
    step();
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    step();
    step();
    chk("mid_bit_cnt", 32'(bit_cnt), 32'd2);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    ser_ready = 1'b0;
    chk_reset_state("mid_rst");

    // Basic word at full throughput.
    run_word(8'hA5, 100, 0, 1'b0, -1, 0, t_a);

    // Backpressure: three stall cycles while bit 2 is presented.
    run_word(8'h3C, 100, 0, 1'b0, 2, 3, t_a);

    // in_valid with 8'hFF pulsed during SHIFT must be ignored.
    run_word(8'h96, 100, 1, 1'b0, -1, 0, t_a);

    // Abort 8'hF0 at bit 4: no done, next word unaffected.
    in_valid = 1'b1;
    in_data  = 8'hF0;
    step();
    in_valid  = 1'b0;
    ser_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("abort_ser_out", 32'(ser_out), 32'(in_data[i]));
      step();
    end
    chk("abort_bit_cnt", 32'(bit_cnt), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ser_ready = 1'b0;
    chk_reset_state("abort");
    step();
    chk("abort_no_done", 32'(done), 32'd0);
    run_word(8'h01, 100, 0, 1'b0, -1, 0, t_a);

    // Back-to-back with in_valid held high.
    run_word(8'h81, 100, 0, 1'b1, -1, 0, t_a);
    run_word(8'h7E, 100, 0, 1'b0, -1, 0, t_b);
    chk("b2b_gap", 32'(t_b - t_a), 32'(W + 2));

    // Randomized words, random backpressure and input noise while busy.
    for (int n = 0; n < 40; n++) begin
      w = W'($urandom);
      repeat ($urandom_range(2)) step();
      run_word(w, $urandom_range(30, 100), 2 * int'($urandom_range(1)), 1'b0, -1, 0, t_a);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
